// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: round-robin sharing of one iterative FP divider between NUM_REQ issue ports
module fdiv_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int exp_width = 8,
  parameter int mant_width = 24,
  parameter int TAG_W = 4,
  parameter int LAT_MAX = mant_width + 4,
  localparam int W = exp_width + mant_width,
  localparam int ID_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(LAT_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*W-1:0]     req_a,
  input  logic [NUM_REQ*W-1:0]     req_b,
  input  logic [NUM_REQ*3-1:0]     req_rm,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       flush_mask,
  output logic                     div_in_valid,
  input  logic                     div_in_ready,
  output logic [W-1:0]             div_a,
  output logic [W-1:0]             div_b,
  output logic [2:0]               div_rm,
  output logic                     div_cancel,
  input  logic                     div_out_valid,
  input  logic [W-1:0]             div_out,
  input  logic [4:0]               div_exc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [W-1:0]             rsp_out,
  output logic [4:0]               rsp_exc,
  output logic                     rsp_err,
  output logic                     timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  logic [1:0] state;
  logic [ID_W-1:0] rr_ptr, op_id, gnt_idx;
  logic gnt_found;
  logic [CNT_W-1:0] busy_cnt;
  logic [W-1:0] op_a, op_b, out_r;
  logic [2:0] op_rm;
  logic [TAG_W-1:0] op_tag;
  logic [4:0] exc_r;
  logic err_r;
  logic [NUM_REQ-1:0] elig;
  logic owner_hit, flush_cancel, timeout_cancel;
  assign elig = req_valid & ~(flush_mask & {NUM_REQ{flush}});
  assign owner_hit = flush & flush_mask[op_id];
  assign flush_cancel = state == S_BUSY && owner_hit;
  assign timeout_cancel = state == S_BUSY && !owner_hit && !div_out_valid && busy_cnt == CNT_W'(LAT_MAX - 1);
  assign div_cancel = rst | flush_cancel | timeout_cancel;
  assign req_ready = (state == S_IDLE && gnt_found && !rst) ? NUM_REQ'(1) << gnt_idx : '0;
  assign div_in_valid = state == S_ISSUE && !owner_hit && !rst;
  assign div_a = op_a;
  assign div_b = op_b;
  assign div_rm = op_rm;
  assign rsp_valid = state == S_RESP && !owner_hit && !rst;
  assign rsp_id = op_id;
  assign rsp_tag = op_tag;
  assign rsp_out = out_r;
  assign rsp_exc = exc_r;
  assign rsp_err = err_r;
  // walk from rr_ptr+NUM_REQ down to rr_ptr+1 so the nearest eligible requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (elig[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        gnt_found = 1'b1;
        gnt_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  // sequencer: grant, launch, wait for result or timeout, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      busy_cnt <= '0;
      op_id <= '0;
      op_a <= '0;
      op_b <= '0;
      op_rm <= '0;
      op_tag <= '0;
      out_r <= '0;
      exc_r <= '0;
      err_r <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (gnt_found) begin
          state <= S_ISSUE;
          rr_ptr <= gnt_idx;
          op_id <= gnt_idx;
          op_a <= req_a[gnt_idx*W +: W];
          op_b <= req_b[gnt_idx*W +: W];
          op_rm <= req_rm[gnt_idx*3 +: 3];
          op_tag <= req_tag[gnt_idx*TAG_W +: TAG_W];
        end
        S_ISSUE: begin
          state <= owner_hit ? S_IDLE : div_in_ready ? S_BUSY : S_ISSUE;
          busy_cnt <= '0;
        end
        S_BUSY: begin
          busy_cnt <= busy_cnt + CNT_W'(1);
          if (owner_hit) state <= S_IDLE;
          else if (div_out_valid) begin
            state <= S_RESP;
            out_r <= div_out;
            exc_r <= div_exc;
            err_r <= 1'b0;
          end else if (timeout_cancel) begin
            state <= S_RESP;
            out_r <= '0;
            exc_r <= 5'b10000;
            err_r <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        default: if (owner_hit || rsp_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule
